warp_ibuf: RTL and testbench

WARP_IBUF -- requirements
Module: warp_ibuf

---
 rtl/warp_pkg.sv | 15 +
 rtl/warp_ibuf_ram.sv | 33 +++
 rtl/warp_ibuf.sv | 89 ++++++++
 tb/tb_warp_ibuf.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_pkg.sv
// Shared definitions for the warp front end: instruction-buffer entry layout
// and a helper that packs an instruction with its RVC flag.
package warp_pkg;

  localparam int INST_W   = 32;
  localparam int ENTRY_W  = INST_W + 1;
  localparam int RVC_BIT  = 0;
  localparam int INST_LSB = 1;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [INST_W-1:0] inst,
                                                    input logic rvc);
    return {inst, rvc};
  endfunction

endpackage

// File: rtl/warp_ibuf_ram.sv
// Instruction buffer storage: two write ports, two asynchronous read ports.
// Contents are intentionally not reset; validity is tracked by the control logic.
module warp_ibuf_ram
  import warp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [AW-1:0]      waddr0,
  input  logic [ENTRY_W-1:0] wdata0,
  input  logic               we1,
  input  logic [AW-1:0]      waddr1,
  input  logic [ENTRY_W-1:0] wdata1,
  input  logic [AW-1:0]      raddr0,
  output logic [ENTRY_W-1:0] rdata0,
  input  logic [AW-1:0]      raddr1,
  output logic [ENTRY_W-1:0] rdata1
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // The two write addresses of one group are always consecutive, so they never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/warp_ibuf.sv
// Two-in / two-out circular instruction buffer between fetch and decode.
// Pointers wrap modulo DEPTH; occupancy carries one extra bit to tell full from empty.
module warp_ibuf
  import warp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_input_valid,
  output logic        o_input_ready,
  input  logic [31:0] i_inst0,
  input  logic [31:0] i_inst1,
  input  logic [1:0]  i_compressed,
  input  logic        i_count,
  output logic [1:0]  o_valid,
  output logic [31:0] o_inst0,
  output logic [31:0] o_inst1,
  output logic [1:0]  o_compressed,
  input  logic [1:0]  i_pop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      occupancy;
  logic               accept;
  logic [1:0]         push_n;
  logic [ENTRY_W-1:0] rd_entry0;
  logic [ENTRY_W-1:0] rd_entry1;

  // Ready depends only on registered occupancy so fetch never sees a pop/flush path.
  assign o_input_ready = (occupancy <= CW'(DEPTH - 2));
  assign accept        = i_input_valid & o_input_ready & ~i_flush;
  assign push_n        = accept ? (i_count ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push_n);
      rd_ptr    <= rd_ptr + AW'(i_pop);
      occupancy <= occupancy + CW'(push_n) - CW'(i_pop);
    end
  end

  warp_ibuf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (i_clk),
    .we0    (accept),
    .waddr0 (wr_ptr),
    .wdata0 (pack_entry(i_inst0, i_compressed[0])),
    .we1    (accept & i_count),
    .waddr1 (wr_ptr + AW'(1)),
    .wdata1 (pack_entry(i_inst1, i_compressed[1])),
    .raddr0 (rd_ptr),
    .rdata0 (rd_entry0),
    .raddr1 (rd_ptr + AW'(1)),
    .rdata1 (rd_entry1)
  );

  assign o_valid      = {occupancy >= CW'(2), occupancy != '0};
  assign o_inst0      = rd_entry0[ENTRY_W-1:INST_LSB];
  assign o_inst1      = rd_entry1[ENTRY_W-1:INST_LSB];
  assign o_compressed = {rd_entry1[RVC_BIT], rd_entry0[RVC_BIT]};

  // Decode may only consume entries that are currently presented as valid.
  a_legal_pop: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_pop <= (2'(o_valid[0]) + 2'(o_valid[1])));

`ifdef WARP_FORMAL
  a_occ_max: assert property (@(posedge i_clk) occupancy <= CW'(DEPTH));
  a_occ_ptr: assert property (@(posedge i_clk)
    (occupancy == CW'(DEPTH)) || (occupancy[AW-1:0] == AW'(wr_ptr - rd_ptr)));
  a_valid_order: assert property (@(posedge i_clk) !o_valid[1] || o_valid[0]);
`endif

endmodule

// File: tb/tb_warp_ibuf.sv
// Self-checking bench for warp_ibuf: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_warp_ibuf;

  localparam int DEPTH = 8;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_input_valid;
  logic        o_input_ready;
  logic [31:0] i_inst0;
  logic [31:0] i_inst1;
  logic [1:0]  i_compressed;
  logic        i_count;
  logic [1:0]  o_valid;
  logic [31:0] o_inst0;
  logic [31:0] o_inst1;
  logic [1:0]  o_compressed;
  logic [1:0]  i_pop;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [32:0] q[$];

  warp_ibuf #(.DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_input_valid (i_input_valid),
    .o_input_ready (o_input_ready),
    .i_inst0       (i_inst0),
    .i_inst1       (i_inst1),
    .i_compressed  (i_compressed),
    .i_count       (i_count),
    .o_valid       (o_valid),
    .o_inst0       (o_inst0),
    .o_inst1       (o_inst1),
    .o_compressed  (o_compressed),
    .i_pop         (i_pop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        flush;
    logic        valid;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [1:0]  comp;
    logic        count;
    logic [1:0]  pop;
    logic [1:0]  exp_valid;
    logic        exp_ready;
    logic [31:0] exp_inst0;
    logic [31:0] exp_inst1;
    logic [1:0]  exp_comp;
  } vec_t;

  vec_t vecs[5];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else
      checks_passed++;
  endtask

  // Drive one cycle of stimulus, advance the model by the same rules, sample after the edge.
  task automatic applyStimulus(input logic flush, input logic valid, input logic [31:0] inst0,
                               input logic [31:0] inst1, input logic [1:0] comp,
                               input logic count, input logic [1:0] pop);
    logic acc;
    i_flush       = flush;
    i_input_valid = valid;
    i_inst0       = inst0;
    i_inst1       = inst1;
    i_compressed  = comp;
    i_count       = count;
    i_pop         = pop;
    acc = valid && ((DEPTH - q.size()) >= 2);
    @(posedge i_clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      for (int k = 0; k < int'(pop); k++) void'(q.pop_front());
      if (acc) begin
        q.push_back({inst0, comp[0]});
        if (count) q.push_back({inst1, comp[1]});
      end
    end
    i_flush       = 1'b0;
    i_input_valid = 1'b0;
    i_pop         = 2'd0;
  endtask

  task automatic checkOutput(input string name);
    int n;
    n = q.size();
    checkVal({name, "_valid"}, 64'(o_valid), 64'({n >= 2, n >= 1}));
    checkVal({name, "_ready"}, 64'(o_input_ready), 64'((DEPTH - n) >= 2));
    if (n >= 1) checkVal({name, "_slot0"}, 64'({o_inst0, o_compressed[0]}), 64'(q[0]));
    if (n >= 2) checkVal({name, "_slot1"}, 64'({o_inst1, o_compressed[1]}), 64'(q[1]));
  endtask

  task automatic doReset();
    i_rst_n       = 1'b0;
    i_flush       = 1'b0;
    i_input_valid = 1'b0;
    i_pop         = 2'd0;
    i_count       = 1'b0;
    i_compressed  = 2'b00;
    q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    checkVal("reset_valid", 64'(o_valid), 64'(2'b00));
    checkVal("reset_ready", 64'(o_input_ready), 64'(1'b1));
    i_rst_n = 1'b1;
  endtask

  function automatic logic [31:0] seq_inst(input int n);
    return 32'h1000_0000 + 32'(n);
  endfunction

  initial begin
    i_inst0 = '0;
    i_inst1 = '0;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0010_0093, 2'b00, 1'b1, 2'd0,
                2'b11, 1'b1, 32'h0000_0013, 32'h0010_0093, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 32'hA0A0_0001, 32'hA1A1_0001, 2'b01, 1'b0, 2'd1,
                2'b11, 1'b1, 32'h0010_0093, 32'hA0A0_0001, 2'b10};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd2,
                2'b00, 1'b1, 32'h0, 32'h0, 2'b00};
    vecs[3] = '{1'b0, 1'b1, 32'hB0B0_0002, 32'hB1B1_0003, 2'b10, 1'b1, 2'd0,
                2'b11, 1'b1, 32'hB0B0_0002, 32'hB1B1_0003, 2'b10};
    vecs[4] = '{1'b1, 1'b1, 32'hC0C0_0004, 32'hC1C1_0005, 2'b11, 1'b1, 2'd1,
                2'b00, 1'b1, 32'h0, 32'h0, 2'b00};

    doReset();
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].flush, vecs[v].valid, vecs[v].inst0, vecs[v].inst1,
                    vecs[v].comp, vecs[v].count, vecs[v].pop);
      checkVal($sformatf("vec%0d_valid", v), 64'(o_valid), 64'(vecs[v].exp_valid));
      checkVal($sformatf("vec%0d_ready", v), 64'(o_input_ready), 64'(vecs[v].exp_ready));
      if (vecs[v].exp_valid[0])
        checkVal($sformatf("vec%0d_slot0", v), 64'({o_inst0, o_compressed[0]}),
                 64'({vecs[v].exp_inst0, vecs[v].exp_comp[0]}));
      if (vecs[v].exp_valid[1])
        checkVal($sformatf("vec%0d_slot1", v), 64'({o_inst1, o_compressed[1]}),
                 64'({vecs[v].exp_inst1, vecs[v].exp_comp[1]}));
    end

    // Fill to capacity with two-wide groups; a fifth group must be refused.
    doReset();
    for (int g = 0; g < 4; g++) begin
      applyStimulus(1'b0, 1'b1, seq_inst(2*g), seq_inst(2*g+1), 2'b00, 1'b1, 2'd0);
      checkOutput($sformatf("fill%0d", g));
    end
    checkVal("full_ready", 64'(o_input_ready), 64'(1'b0));
    applyStimulus(1'b0, 1'b1, 32'hDEAD_0001, 32'hDEAD_0002, 2'b11, 1'b1, 2'd0);
    checkVal("fifth_refused_ready", 64'(o_input_ready), 64'(1'b0));
    checkVal("fifth_refused_head", 64'(o_inst0), 64'(seq_inst(0)));
    for (int d = 0; d < 4; d++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd2);
      checkOutput($sformatf("drain%0d", d));
    end

    // Occupancy 7: ready is low, so a one-wide offer alongside a pop of 2 is refused.
    doReset();
    for (int g = 0; g < 3; g++)
      applyStimulus(1'b0, 1'b1, seq_inst(2*g), seq_inst(2*g+1), 2'b00, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b1, seq_inst(6), 32'h0, 2'b01, 1'b0, 2'd0);
    checkVal("occ7_ready", 64'(o_input_ready), 64'(1'b0));
    applyStimulus(1'b0, 1'b1, 32'hEEEE_0007, 32'h0, 2'b00, 1'b0, 2'd2);
    checkOutput("occ7_push_pop");
    checkVal("occ7_head", 64'(o_inst0), 64'(seq_inst(2)));
    // Now wr_ptr=7 and rd_ptr=2: a two-wide push straddles index 7 -> 0.
    applyStimulus(1'b0, 1'b1, 32'hAAAA_0007, 32'hBBBB_0000, 2'b10, 1'b1, 2'd0);
    checkOutput("wrap_push");
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd1);
    checkVal("wrap_valid", 64'(o_valid), 64'(2'b11));
    checkVal("wrap_inst0", 64'(o_inst0), 64'(32'hAAAA_0007));
    checkVal("wrap_inst1", 64'(o_inst1), 64'(32'hBBBB_0000));
    checkVal("wrap_comp", 64'(o_compressed), 64'(2'b10));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd2);
    checkVal("wrap_empty", 64'(o_valid), 64'(2'b00));

    // Flush at occupancy 5 wins over a simultaneous push and pop.
    doReset();
    applyStimulus(1'b0, 1'b1, seq_inst(0), seq_inst(1), 2'b00, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b1, seq_inst(2), seq_inst(3), 2'b00, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b1, seq_inst(4), 32'h0, 2'b00, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 32'hF00D_0001, 32'hF00D_0002, 2'b00, 1'b1, 2'd1);
    checkVal("flush_valid", 64'(o_valid), 64'(2'b00));
    checkVal("flush_ready", 64'(o_input_ready), 64'(1'b1));
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 32'h0, 2'b01, 1'b0, 2'd0);
    checkVal("after_flush_valid", 64'(o_valid), 64'(2'b01));
    checkVal("after_flush_inst0", 64'(o_inst0), 64'(32'h1234_5678));

    // Asynchronous reset at occupancy 3 clears outputs before any clock edge.
    doReset();
    applyStimulus(1'b0, 1'b1, seq_inst(0), seq_inst(1), 2'b00, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b1, seq_inst(2), 32'h0, 2'b00, 1'b0, 2'd0);
    checkOutput("pre_async");
    #2;
    i_rst_n = 1'b0;
    q.delete();
    #1;
    checkVal("async_rst_valid", 64'(o_valid), 64'(2'b00));
    checkVal("async_rst_ready", 64'(o_input_ready), 64'(1'b1));
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0);
    checkOutput("post_async");

    // Randomized traffic with legal pops only.
    doReset();
    for (int c = 0; c < 600; c++) begin
      int n;
      int maxpop;
      n = q.size();
      maxpop = (n < 2) ? n : 2;
      applyStimulus($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, maxpop)));
      checkOutput($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
